// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Single-port video RAM arbiter between VGA scanout and CPU, with
//            VGA priority, CPU anti-starvation and registered read steering.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [7:0]  C_MAX_WAIT = 8'(MAX_WAIT);
  localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_conflict_cnt;
  logic        w_force_cpu;
  logic        w_vga_gnt;
  logic        w_cpu_gnt;

  // Grants are gated by reset_n so nothing reaches the RAM while held in reset.
  assign w_force_cpu = cpu_req & (r_wait_cnt == C_MAX_WAIT);
  assign w_vga_gnt   = reset_n & vga_req & ~w_force_cpu;
  assign w_cpu_gnt   = reset_n & cpu_req & ~w_vga_gnt;

  assign vga_gnt   = w_vga_gnt;
  assign cpu_gnt   = w_cpu_gnt;
  assign mem_en    = w_vga_gnt | w_cpu_gnt;
  assign mem_we    = w_cpu_gnt & cpu_we;
  assign mem_addr  = w_vga_gnt ? vga_addr : cpu_addr;
  assign mem_wdata = cpu_wdata;

  // Owner tag: which port the data returning next cycle belongs to.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_vga_gnt) begin
      w_owner_nxt = OWN_VGA;
    end else if (w_cpu_gnt && !cpu_we) begin
      w_owner_nxt = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 8'd0;
    end else if (cpu_req && !w_cpu_gnt) begin
      if (r_wait_cnt != C_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_cnt <= 16'd0;
    end else if (vga_req && cpu_req && (r_conflict_cnt != C_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign vga_rvalid   = (r_owner == OWN_VGA);
  assign cpu_rvalid   = (r_owner == OWN_CPU);
  assign vga_rdata    = mem_rdata;
  assign cpu_rdata    = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Randomised + directed scoreboard bench for vram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 12;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_gnt, vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       conflict_cnt;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 16'h0010) return 12'hABC;
    return 12'(a * 37 + 5);
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [DATA_W-1:0] ram_val [0:65535];
  bit                ram_wr  [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram_val[mem_addr] <= mem_wdata;
        ram_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram_val[mem_addr] : init_val(mem_addr);
      end
    end else begin
      mem_rdata <= 12'($urandom);
    end
  end

  // Reference model state
  logic [DATA_W-1:0] sh_val [0:65535];
  bit                sh_wr  [0:65535];
  int m_wait = 0;
  int m_conf = 0;
  bit m_last_ev = 0;
  bit m_last_ec = 0;

  typedef struct packed {
    logic              port;  // 1 = CPU
    logic [DATA_W-1:0] data;
    int                cyc;
  } ret_t;
  ret_t q[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] sh_rd(input logic [ADDR_W-1:0] a);
    return sh_wr[a] ? sh_val[a] : init_val(a);
  endfunction

  // Called late in the cycle: compare grants/memory strobes, then advance the model.
  task automatic check_cycle();
    bit ev, ec;
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
    ev = 0; ec = 0;
    if (reset_n) begin
      ev = vga_req && !(cpu_req && m_wait == MAX_WAIT);
      ec = cpu_req && !ev;
    end
    chk("vga_gnt", 32'(vga_gnt), 32'(ev));
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    chk("mem_en", 32'(mem_en), 32'(ev | ec));
    chk("mem_we", 32'(mem_we), 32'(ec & cpu_we));
    if (ev) chk("mem_addr vga", 32'(mem_addr), 32'(vga_addr));
    if (ec) chk("mem_addr cpu", 32'(mem_addr), 32'(cpu_addr));
    if (ec && cpu_we) chk("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
    m_last_ev = ev;
    m_last_ec = ec;
    if (reset_n) begin
      if (ev) q.push_back('{port: 1'b0, data: sh_rd(vga_addr), cyc: cyc + 1});
      if (ec && cpu_we) begin
        sh_val[cpu_addr] = cpu_wdata;
        sh_wr[cpu_addr]  = 1'b1;
      end
      if (ec && !cpu_we) q.push_back('{port: 1'b1, data: sh_rd(cpu_addr), cyc: cyc + 1});
      if (cpu_req && !ec) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      if (vga_req && cpu_req && m_conf < 65535) m_conf++;
    end
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic step();
    #3;
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    q.delete();
    m_wait = 0;
    m_conf = 0;
    vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    for (int i = 0; i < n; i++) step();
    vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    reset_n = 1'b1;
  endtask

  // Monitor: every return must land exactly on its scheduled cycle and port.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_total++;
      n_bad++;
      $display("FAIL missing return: port=%0d expected data %0h (cycle %0d)", q[0].port, q[0].data, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("vga_rvalid", 32'(vga_rvalid), 32'(!q[0].port));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(q[0].port));
      if (q[0].port) chk("cpu_rdata", 32'(cpu_rdata), 32'(q[0].data));
      else           chk("vga_rdata", 32'(vga_rdata), 32'(q[0].data));
      void'(q.pop_front());
    end else begin
      chk("idle vga_rvalid", 32'(vga_rvalid), 32'd0);
      chk("idle cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    // Lone CPU read of preloaded word
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #3; chk("lone cpu_gnt", 32'(cpu_gnt), 32'd1); #(-0);
    check_cycle(); @(posedge clk); #1;
    cpu_req = 1'b0;
    #1;
    chk("read cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("read cpu_rdata", 32'(cpu_rdata), 32'hABC);
    #(-0);
    #2; check_cycle(); @(posedge clk); #1;

    // CPU write then VGA read-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 12'h5A5;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    vga_req = 1'b1; vga_addr = 16'h0020;
    step();
    vga_req = 1'b0;
    #1;
    chk("wb vga_rdata", 32'(vga_rdata), 32'h5A5);
    chk("wb cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    #2; check_cycle(); @(posedge clk); #1;

    // Continuous contention: VGA x8 then forced CPU, repeating
    do_reset(2);
    vga_req = 1'b1; vga_addr = 16'h0003;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0004;
    for (int i = 0; i < 27; i++) begin
      #3;
      chk("starve pattern cpu_gnt", 32'(cpu_gnt), 32'(i % 9 == 8));
      check_cycle();
      @(posedge clk);
      #1;
    end
    chk("conflict after 27", 32'(conflict_cnt), 32'd27);
    vga_req = 1'b0; cpu_req = 1'b0;
    step();

    // Alternating single-port reads
    for (int i = 0; i < 20; i++) begin
      vga_req = (i % 2 == 0); cpu_req = (i % 2 == 1); cpu_we = 1'b0;
      vga_addr = 16'($urandom_range(0, 15));
      cpu_addr = 16'($urandom_range(0, 15));
      step();
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    step();

    // Reset in the cycle after a VGA read grant
    vga_req = 1'b1; vga_addr = 16'h0007;
    step();
    reset_n = 1'b0;
    q.delete(); m_wait = 0; m_conf = 0;
    #1;
    chk("rst vga_rvalid", 32'(vga_rvalid), 32'd0);
    chk("rst conflict", 32'(conflict_cnt), 32'd0);
    #(-0);
    #2; check_cycle(); @(posedge clk); #1;
    do_reset(2);

    // Randomised traffic, each request held until granted
    for (int i = 0; i < 3000; i++) begin
      if (!vga_req || m_last_ev) begin
        vga_req  = ($urandom_range(0, 2) != 0);
        vga_addr = 16'($urandom_range(0, 15));
      end
      if (!cpu_req || m_last_ec) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 16'($urandom_range(0, 15));
        cpu_wdata = 12'($urandom);
      end
      step();
    end

    // Long contention for counter saturation
    vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    chk("conflict saturated", 32'(conflict_cnt), 32'hFFFF);

    vga_req = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
